// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core -- 8N1 UART transmitter with an optional parity bit.
//
// Frames a byte as START(0), eight data bits LSB first, an optional parity
// bit and STOP(1). Each bit is held for BAUD_DIV+1 clock cycles.
//
// Parameters
//   BAUD_DIV    clock cycles per bit minus one (14 bits, 0 is legal)
//   PARITY_ODD  parity sense when parity is compiled in: 0 even, 1 odd
//
// Compile-time option
//   UART_TX_PARITY_EN  when defined, a parity bit is sent between the last
//                      data bit and the stop bit (11-bit frame); when
//                      undefined the frame is 10 bits and PARITY_ODD has no
//                      effect.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   tx_data_i       byte to send, sampled only on the accept cycle
//   tx_valid_i      requester offers tx_data_i
//   tx_ready_o      core is idle and accepts a byte this cycle
//   uart_tx_o       registered serial line, idle high
//   uart_tx_busy_o  high from START through STOP
//   uart_tx_done_o  one-cycle pulse on the last cycle of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_core #(
  parameter logic [13:0] BAUD_DIV   = 14'd10416,
  parameter logic        PARITY_ODD = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       uart_tx_o,
  output logic       uart_tx_busy_o,
  output logic       uart_tx_done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        accept;
  logic        bit_end;

  assign accept  = tx_valid_i && (state_q == S_IDLE);
  // The counter is held at zero in IDLE, so this strobe is only meaningful
  // in the active states; every consumer below is qualified by state.
  assign bit_end = (cnt_q == BAUD_DIV);

`ifdef UART_TX_PARITY_EN
  // Parity is computed once from the byte as accepted; the shift register
  // is destroyed while the data bits go out, so it cannot be used later.
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = (^tx_data_i) ^ PARITY_ODD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  // Without a parity bit the sense parameter selects nothing.
  if (PARITY_ODD != 1'b0) begin : g_parity_sense_ignored
  end
`endif

  // Baud counter: restarts on accept and at every bit boundary.
  always_comb begin
    cnt_d = 14'd0;
    if (state_q != S_IDLE && !bit_end) begin
      cnt_d = cnt_q + 14'd1;
    end
  end

  // Next-state, shift register and bit index.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid_i) begin
          state_d = S_START;
          shift_d = tx_data_i;
          idx_d   = 3'd0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        shift_d = 8'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // The line level is decoded from the *next* state so the registered
  // output changes on the same edge as the state, e.g. it drops on the
  // edge that accepts a byte. An illegal state decodes to IDLE, so the
  // line is high again on the following cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 14'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_ready_o     = (state_q == S_IDLE);
  assign uart_tx_busy_o = (state_q != S_IDLE);
  assign uart_tx_done_o = (state_q == S_STOP) && bit_end;
  assign uart_tx_o      = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
`timescale 1ns/1ps
module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, line_a, busy_a, done_a;
  logic       ready_b, line_b, busy_b, done_b;
  logic       sel_b = 1'b0;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  // Main DUT: 4 cycles per bit, even parity.
  uart_tx_core #(.BAUD_DIV(14'd3), .PARITY_ODD(1'b0)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(data_a), .tx_valid_i(valid_a),
    .tx_ready_o(ready_a), .uart_tx_o(line_a), .uart_tx_busy_o(busy_a),
    .uart_tx_done_o(done_a)
  );

  // Boundary DUT: 1 cycle per bit, odd parity.
  uart_tx_core #(.BAUD_DIV(14'd0), .PARITY_ODD(1'b1)) u_dut_fast (
    .clk_i(clk), .rst_n_i(rst_n), .tx_data_i(data_b), .tx_valid_i(valid_b),
    .tx_ready_o(ready_b), .uart_tx_o(line_b), .uart_tx_busy_o(busy_b),
    .uart_tx_done_o(done_b)
  );

  wire obs_line  = sel_b ? line_b  : line_a;
  wire obs_ready = sel_b ? ready_b : ready_a;
  wire obs_busy  = sel_b ? busy_b  : busy_a;
  wire obs_done  = sel_b ? done_b  : done_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte on an idle DUT; returns one cycle after the accept edge.
  task automatic send(input logic [7:0] d, input bit hold);
    chk("ready_before_accept", {31'd0, obs_ready}, 32'd1);
    if (sel_b) begin valid_b = 1'b1; data_b = d; end
    else       begin valid_a = 1'b1; data_a = d; end
    sb.push_back(d);
    tick();
    if (!hold) begin valid_a = 1'b0; valid_b = 1'b0; end
    // Changing the data bus after accept must not disturb the frame.
    data_a = ~d;
    data_b = ~d;
    $display("send 0x%02h on %s dut", d, sel_b ? "fast" : "main");
  endtask

  // Observe one whole frame starting in the first cycle after accept,
  // decode it and compare against the scoreboard head.
  task automatic watch_frame(input bit inject);
    int cpb;
    int n;
    int done_cnt;
    int done_at;
    int rdy_cnt;
    int idle_cnt;
    int width_err;
    logic ls [1:64];
    logic [NB-1:0] v;
    logic [7:0] exp_byte;
    logic [7:0] got;
    cpb = sel_b ? 1 : 4;
    n = NB * cpb;
    done_cnt = 0; done_at = -1; rdy_cnt = 0; idle_cnt = 0; width_err = 0;
    for (int k = 1; k <= n; k++) begin
      ls[k] = obs_line;
      if (obs_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (obs_ready !== 1'b0) rdy_cnt++;
      if (obs_busy !== 1'b1) idle_cnt++;
      if (inject && k == 10) begin valid_a = 1'b1; data_a = 8'h00; end
      if (inject && k == 11) valid_a = 1'b0;
      tick();
    end
    for (int b = 0; b < NB; b++) begin
      v[b] = ls[b*cpb + 1];
      for (int j = 1; j < cpb; j++)
        if (ls[b*cpb + 1 + j] !== v[b]) width_err++;
    end
    chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
    exp_byte = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    got = v[8:1];
    chk("start_bit", {31'd0, v[0]}, 32'd0);
    chk("data_byte", {24'd0, got}, {24'd0, exp_byte});
`ifdef UART_TX_PARITY_EN
    chk("parity_bit", {31'd0, v[9]}, {31'd0, (^exp_byte) ^ sel_b});
`endif
    chk("stop_bit", {31'd0, v[NB-1]}, 32'd1);
    chk("bit_width", width_err, 0);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_at, n);
    chk("ready_low_in_frame", rdy_cnt, 0);
    chk("busy_high_in_frame", idle_cnt, 0);
    $display("frame decoded 0x%02h expected 0x%02h done@%0d", got, exp_byte, done_at);
  endtask

  initial begin
    int bad_line, bad_ready, bad_busy, dpulse;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_line",  {31'd0, line_a},  32'd1);
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    chk("rst_busy",  {31'd0, busy_a},  32'd0);
    chk("rst_done",  {31'd0, done_a},  32'd0);
    $display("reset asserted, outputs checked");
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Idle for 20 cycles.
    bad_line = 0; bad_ready = 0; bad_busy = 0; dpulse = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (line_a !== 1'b1) bad_line++;
      if (ready_a !== 1'b1) bad_ready++;
      if (busy_a !== 1'b0) bad_busy++;
      if (done_a !== 1'b0) dpulse++;
    end
    chk("idle_line", bad_line, 0);
    chk("idle_ready", bad_ready, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_done", dpulse, 0);
    $display("idle 20 cycles checked");

    // Single frame 0x55.
    send(8'h55, 1'b0);
    watch_frame(1'b0);
    chk("post_frame_line", {31'd0, line_a}, 32'd1);
    chk("post_frame_ready", {31'd0, ready_a}, 32'd1);

    // Back-to-back frames with valid held high.
    send(8'hA5, 1'b1);
    data_a = 8'h3C;
    sb.push_back(8'h3C);
    watch_frame(1'b0);
    // One IDLE cycle with the line still high, then the second start bit.
    chk("b2b_gap_line", {31'd0, line_a}, 32'd1);
    chk("b2b_gap_ready", {31'd0, ready_a}, 32'd1);
    tick();
    valid_a = 1'b0;
    watch_frame(1'b0);

    // Ignored request during a frame.
    send(8'hFF, 1'b0);
    watch_frame(1'b1);
    chk("inject_ignored_ready", {31'd0, ready_a}, 32'd1);
    chk("inject_ignored_line", {31'd0, line_a}, 32'd1);

    // Reset mid-DATA of 0x81.
    send(8'h81, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("abort_line", {31'd0, line_a}, 32'd1);
    chk("abort_ready", {31'd0, ready_a}, 32'd1);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    sb.delete();
    dpulse = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_a !== 1'b0) dpulse++;
    end
    chk("abort_no_done", dpulse, 0);
    rst_n = 1'b1;
    $display("reset mid-frame checked");
    tick();
    send(8'h81, 1'b0);
    watch_frame(1'b0);

    // Parity sample byte.
    send(8'h07, 1'b0);
    watch_frame(1'b0);

    // One cycle per bit.
    sel_b = 1'b1;
    send(8'h5A, 1'b0);
    watch_frame(1'b0);
    send(8'h07, 1'b0);
    watch_frame(1'b0);
    sel_b = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
